// File: rtl/note_step_sequencer.sv
// Step sequencer that plays a host-programmed note loop on tone channel A by
// issuing one-cycle register writes to the signal_generator write port.
module note_step_sequencer #(
  parameter int         STEPS    = 8,
  parameter int         TICK_DIV = 64,
  parameter logic [1:0] EN_BN    = 2'b11,
  localparam int        SW       = $clog2(STEPS),
  localparam int        PW       = $clog2(TICK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          prog_we,
  input  logic [SW-1:0] prog_addr,
  input  logic [9:0]    prog_data,
  input  logic [SW-1:0] loop_end,
  input  logic [7:0]    tempo,
  input  logic [7:0]    gate_len,
  output logic          wr_strobe,
  output logic [2:0]    wr_addr,
  output logic [4:0]    wr_data,
  output logic [SW-1:0] step_idx,
  output logic          busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PER  = 3'd1;
  localparam logic [2:0] S_VOL  = 3'd2;
  localparam logic [2:0] S_ON   = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;
  localparam logic [2:0] S_OFF  = 3'd5;
  localparam logic [2:0] S_STOP = 3'd6;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [9:0]    r_ram [STEPS];
  logic [9:0]    r_word;
  logic [9:0]    w_word_n;
  logic [SW-1:0] r_idx;
  logic [SW-1:0] w_nidx;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_tcnt;
  logic          r_off_done;
  logic          r_off_burst;
  logic          w_tick;
  logic          w_counting;
  logic          w_step_hit;
  logic          w_gate_hit;
  logic          w_burst;
  logic          w_clr;

  // The prescaler sits at 0 through the burst, so tick phase is anchored to
  // the last write of the burst (W_ON, or W_OFF for a rest step).
  assign w_tick     = (r_pre == PW'(TICK_DIV - 1));
  // Ticks accumulate in HOLD and keep going through a gate note-off write.
  assign w_counting = (r_state == S_HOLD) || ((r_state == S_OFF) && !r_off_burst);
  // Step and gate counts are cleared together and count the same ticks, so
  // a single counter serves both comparisons.
  assign w_step_hit = w_counting && w_tick && (r_tcnt == tempo);
  assign w_gate_hit = (r_state == S_HOLD) && w_tick && r_word[9] && !r_off_done &&
                      (({1'b0, r_tcnt} + 9'd1) >= {1'b0, gate_len});
  assign w_clr      = (r_state == S_ON) || ((r_state == S_OFF) && r_off_burst);
  assign w_nidx     = (r_state == S_IDLE) ? '0 :
                      (r_idx >= loop_end) ? '0 : r_idx + SW'(1);
  assign w_word_n   = r_ram[w_nidx];

  // Next-state selection; run=0 always routes through W_STOP after the current write.
  always_comb begin
    w_next  = r_state;
    w_burst = 1'b0;
    case (r_state)
      S_IDLE: w_burst = run;
      S_PER:  w_next  = run ? S_VOL  : S_STOP;
      S_VOL:  w_next  = run ? S_ON   : S_STOP;
      S_ON:   w_next  = run ? S_HOLD : S_STOP;
      S_OFF:  w_next  = run ? S_HOLD : S_STOP;
      S_STOP: w_next  = S_IDLE;
      S_HOLD: begin
        if (!run)           w_next  = S_STOP;
        else if (w_step_hit) w_burst = 1'b1;
        else if (w_gate_hit) w_next  = S_OFF;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_burst) w_next = w_word_n[9] ? S_PER : S_OFF;
  end

  // FSM, step index and latched step word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_word      <= '0;
      r_off_burst <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_burst) begin
        r_idx       <= w_nidx;
        r_word      <= w_word_n;
        r_off_burst <= ~w_word_n[9];
      end else if ((r_state == S_HOLD) && (w_next == S_OFF)) begin
        r_off_burst <= 1'b0;
      end
      if (w_next == S_IDLE) r_idx <= '0;
    end
  end

  // Tick prescaler, held at 0 from burst start until the burst's last write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               r_pre <= '0;
    else if (w_burst || r_state == S_PER || r_state == S_VOL) r_pre <= '0;
    else if (w_tick)                                       r_pre <= '0;
    else                                                   r_pre <= r_pre + PW'(1);
  end

  // Tick counter for step length and gate time, plus the one-shot note-off flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt     <= '0;
      r_off_done <= 1'b0;
    end else if (w_clr) begin
      r_tcnt     <= '0;
      r_off_done <= 1'b0;
    end else begin
      if (w_counting && w_tick) r_tcnt <= r_tcnt + 8'd1;
      if (w_gate_hit && run && !w_step_hit) r_off_done <= 1'b1;
    end
  end

  // Pattern RAM; writable at any time, cleared to rests on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) r_ram[i] <= '0;
    end else if (prog_we) begin
      r_ram[prog_addr] <= prog_data;
    end
  end

  // Register write port decoded from state so reset clears it immediately.
  always_comb begin
    wr_strobe = 1'b0;
    wr_addr   = 3'b000;
    wr_data   = 5'b00000;
    case (r_state)
      S_PER: begin
        wr_strobe = 1'b1;
        wr_addr   = 3'b000;
        wr_data   = r_word[4:0];
      end
      S_VOL: begin
        wr_strobe = 1'b1;
        wr_addr   = 3'b010;
        wr_data   = {1'b0, r_word[8:5]};
      end
      S_ON: begin
        wr_strobe = 1'b1;
        wr_addr   = 3'b101;
        wr_data   = {2'b00, 1'b1, EN_BN};
      end
      S_OFF, S_STOP: begin
        wr_strobe = 1'b1;
        wr_addr   = 3'b101;
        wr_data   = {2'b00, 1'b0, EN_BN};
      end
      default: ;
    endcase
  end

  assign step_idx = r_idx;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_note_step_sequencer.sv
// Directed bench for note_step_sequencer with an 8-cycle tick.
module tb_note_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       prog_we = 1'b0;
  logic [2:0] prog_addr = '0;
  logic [9:0] prog_data = '0;
  logic [2:0] loop_end = '0;
  logic [7:0] tempo = '0;
  logic [7:0] gate_len = '0;
  logic       wr_strobe;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic [2:0] step_idx;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  note_step_sequencer #(.STEPS(8), .TICK_DIV(8), .EN_BN(2'b11)) dut (
    .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .loop_end(loop_end), .tempo(tempo), .gate_len(gate_len),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .step_idx(step_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    run = 1'b0; prog_we = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic prog(input logic [2:0] a, input logic [9:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Advance negedges until a strobe is seen; n is the distance in cycles.
  task automatic wait_strobe(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_strobe && n <= max_cyc);
  endtask

  task automatic test_reset();
    int n;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({wr_strobe, busy, step_idx, wr_addr, wr_data} !== 12'd0) begin
        miscompares++;
        $display("FAIL reset_idle: got strobe=%b busy=%b idx=%0d addr=%b data=%h, expected all 0",
                 wr_strobe, busy, step_idx, wr_addr, wr_data);
      end
    end
    // Every step after reset must play back as a rest (lone note-off write).
    loop_end = 3'd7; tempo = 8'd0; gate_len = 8'd0;
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_strobe(20, n);
      vectors++;
      if (n !== ((i == 0) ? 1 : 8) || {wr_addr, wr_data} !== 8'b101_00011 || step_idx !== 3'(i)) begin
        miscompares++;
        $display("FAIL reset_rest%0d: got n=%0d addr=%b data=%h idx=%0d, expected n=%0d 101/03 idx=%0d",
                 i, n, wr_addr, wr_data, step_idx, (i == 0) ? 1 : 8, i);
      end
    end
    run = 1'b0;
    wait_strobe(5, n);
    vectors++;
    if (n !== 1 || {wr_addr, wr_data} !== 8'b101_00011) begin
      miscompares++;
      $display("FAIL reset_stop: got n=%0d addr=%b data=%h, expected n=1 101/03", n, wr_addr, wr_data);
    end
    @(negedge clk);
    vectors++;
    if ({wr_strobe, busy, step_idx} !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_stop_idle: got strobe=%b busy=%b idx=%0d, expected 0 0 0", wr_strobe, busy, step_idx);
    end
  endtask

  task automatic test_gate_loop();
    int n;
    apply_reset();
    prog(3'd0, 10'h325);
    loop_end = 3'd1; tempo = 8'd3; gate_len = 8'd2;
    @(negedge clk);
    run = 1'b1;
    wait_strobe(5, n);
    vectors++;
    if (n !== 1 || {wr_addr, wr_data} !== 8'b000_00101 || step_idx !== 3'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL gate_per: got n=%0d addr=%b data=%h idx=%0d busy=%b, expected n=1 000/05 idx=0 busy=1",
               n, wr_addr, wr_data, step_idx, busy);
    end
    @(negedge clk);
    vectors++;
    if ({wr_strobe, wr_addr, wr_data} !== 9'b1_010_01001) begin
      miscompares++;
      $display("FAIL gate_vol: got strobe=%b addr=%b data=%h, expected 1 010/09", wr_strobe, wr_addr, wr_data);
    end
    @(negedge clk);
    vectors++;
    if ({wr_strobe, wr_addr, wr_data} !== 9'b1_101_00111) begin
      miscompares++;
      $display("FAIL gate_on: got strobe=%b addr=%b data=%h, expected 1 101/07", wr_strobe, wr_addr, wr_data);
    end
    wait_strobe(40, n);
    vectors++;
    if (n !== 16 || {wr_addr, wr_data} !== 8'b101_00011 || step_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL gate_off: got n=%0d addr=%b data=%h idx=%0d, expected n=16 101/03 idx=0",
               n, wr_addr, wr_data, step_idx);
    end
    wait_strobe(40, n);
    vectors++;
    if (n !== 16 || {wr_addr, wr_data} !== 8'b101_00011 || step_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL gate_step1: got n=%0d addr=%b data=%h idx=%0d, expected n=16 101/03 idx=1",
               n, wr_addr, wr_data, step_idx);
    end
    wait_strobe(40, n);
    vectors++;
    if (n !== 32 || {wr_addr, wr_data} !== 8'b000_00101 || step_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL gate_wrap: got n=%0d addr=%b data=%h idx=%0d, expected n=32 000/05 idx=0",
               n, wr_addr, wr_data, step_idx);
    end
    run = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_legato();
    int n;
    apply_reset();
    prog(3'd0, 10'h325);
    loop_end = 3'd1; tempo = 8'd3; gate_len = 8'd4;
    @(negedge clk);
    run = 1'b1;
    wait_strobe(5, n);
    @(negedge clk);
    @(negedge clk);
    wait_strobe(40, n);
    vectors++;
    if (n !== 32 || {wr_addr, wr_data} !== 8'b101_00011 || step_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL legato_step1: got n=%0d addr=%b data=%h idx=%0d, expected n=32 101/03 idx=1",
               n, wr_addr, wr_data, step_idx);
    end
    wait_strobe(40, n);
    vectors++;
    if (n !== 32 || {wr_addr, wr_data} !== 8'b000_00101 || step_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL legato_step0: got n=%0d addr=%b data=%h idx=%0d, expected n=32 000/05 idx=0",
               n, wr_addr, wr_data, step_idx);
    end
  endtask

  // Runs on from test_legato, which leaves the loop playing step 0.
  task automatic test_stop_restart();
    int n;
    @(negedge clk);
    @(negedge clk);
    wait_strobe(40, n);
    repeat (3) @(negedge clk);
    vectors++;
    if ({wr_strobe, busy, step_idx} !== 5'b0_1_001) begin
      miscompares++;
      $display("FAIL stop_hold: got strobe=%b busy=%b idx=%0d, expected 0 1 1", wr_strobe, busy, step_idx);
    end
    run = 1'b0;
    wait_strobe(5, n);
    vectors++;
    if (n !== 1 || {wr_addr, wr_data} !== 8'b101_00011) begin
      miscompares++;
      $display("FAIL stop_write: got n=%0d addr=%b data=%h, expected n=1 101/03", n, wr_addr, wr_data);
    end
    @(negedge clk);
    vectors++;
    if ({wr_strobe, busy, step_idx} !== 5'd0) begin
      miscompares++;
      $display("FAIL stop_idle: got strobe=%b busy=%b idx=%0d, expected 0 0 0", wr_strobe, busy, step_idx);
    end
    run = 1'b1;
    wait_strobe(5, n);
    vectors++;
    if (n !== 1 || {wr_addr, wr_data} !== 8'b000_00101 || step_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL stop_replay: got n=%0d addr=%b data=%h idx=%0d, expected n=1 000/05 idx=0",
               n, wr_addr, wr_data, step_idx);
    end
    run = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midburst();
    int n;
    int cnt;
    apply_reset();
    prog(3'd0, 10'h325);
    loop_end = 3'd0; tempo = 8'd3; gate_len = 8'd2;
    @(negedge clk);
    run = 1'b1;
    wait_strobe(5, n);
    @(negedge clk);
    vectors++;
    if ({wr_strobe, wr_addr} !== 4'b1_010) begin
      miscompares++;
      $display("FAIL rstmid_vol: got strobe=%b addr=%b, expected 1 010", wr_strobe, wr_addr);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({wr_strobe, wr_addr, wr_data, busy, step_idx} !== 13'd0) begin
      miscompares++;
      $display("FAIL rstmid_clear: got strobe=%b addr=%b data=%h busy=%b idx=%0d, expected all 0",
               wr_strobe, wr_addr, wr_data, busy, step_idx);
    end
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (wr_strobe) cnt++;
    end
    vectors++;
    if (cnt !== 0) begin
      miscompares++;
      $display("FAIL rstmid_quiet: got %0d strobes, expected 0", cnt);
    end
    // Reset also cleared the pattern, so step 0 now plays as a rest.
    run = 1'b1;
    wait_strobe(5, n);
    vectors++;
    if (n !== 1 || {wr_addr, wr_data} !== 8'b101_00011) begin
      miscompares++;
      $display("FAIL rstmid_ramclr: got n=%0d addr=%b data=%h, expected n=1 101/03", n, wr_addr, wr_data);
    end
    run = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loop_shrink();
    int n;
    apply_reset();
    prog(3'd6, 10'h267);
    loop_end = 3'd7; tempo = 8'd0; gate_len = 8'd4;
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 6; i++) wait_strobe(20, n);
    wait_strobe(20, n);
    vectors++;
    if (n !== 8 || {wr_addr, wr_data} !== 8'b000_00111 || step_idx !== 3'd6) begin
      miscompares++;
      $display("FAIL shrink_step6: got n=%0d addr=%b data=%h idx=%0d, expected n=8 000/07 idx=6",
               n, wr_addr, wr_data, step_idx);
    end
    @(negedge clk);
    @(negedge clk);
    loop_end = 3'd2;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(20, n);
      vectors++;
      if (n !== 8 || {wr_addr, wr_data} !== 8'b101_00011 || step_idx !== 3'(i % 3)) begin
        miscompares++;
        $display("FAIL shrink_wrap%0d: got n=%0d addr=%b data=%h idx=%0d, expected n=8 101/03 idx=%0d",
                 i, n, wr_addr, wr_data, step_idx, i % 3);
      end
    end
    run = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_live_write();
    int n;
    apply_reset();
    prog(3'd0, 10'h325);
    loop_end = 3'd0; tempo = 8'd3; gate_len = 8'd4;
    @(negedge clk);
    run = 1'b1;
    wait_strobe(5, n);
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = 10'h28A;
    @(negedge clk);
    prog_we = 1'b0;
    vectors++;
    if ({wr_addr, wr_data} !== 8'b010_01001) begin
      miscompares++;
      $display("FAIL live_cur_vol: got addr=%b data=%h, expected 010/09", wr_addr, wr_data);
    end
    @(negedge clk);
    wait_strobe(40, n);
    vectors++;
    if (n !== 32 || {wr_addr, wr_data} !== 8'b000_01010) begin
      miscompares++;
      $display("FAIL live_next_per: got n=%0d addr=%b data=%h, expected n=32 000/0a", n, wr_addr, wr_data);
    end
    @(negedge clk);
    vectors++;
    if ({wr_addr, wr_data} !== 8'b010_00100) begin
      miscompares++;
      $display("FAIL live_next_vol: got addr=%b data=%h, expected 010/04", wr_addr, wr_data);
    end
    run = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_gate_loop();
    test_legato();
    test_stop_restart();
    test_reset_midburst();
    test_loop_shrink();
    test_live_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
